// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes decoded MIPS descriptors and streams them into IM from BASE_ADDR.
// Optional `define ENC_WRCNT_EN adds a saturating wr_count of acked writes.
module instr_encoder_loader #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [25:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
`ifdef ENC_WRCNT_EN
    output logic [15:0] wr_count,
`endif
    output logic        done,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [32:0]   fifo [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   enc;
    logic [15:0]   imm16;
    logic          op_ok, full, empty, accept, push, pop, head_last;

    assign imm16 = in_imm[15:0];
    // Fields an opcode does not use are driven as zero, never passed through.
    always_comb begin
        enc   = '0;
        op_ok = 1'b1;
        case (in_op)
            5'd0:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
            5'd1:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
            5'd2:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'b100110};
            5'd3:  enc = {6'd0, in_rs, 15'd0, 6'b001000};
            5'd4:  enc = {6'd0, in_rs, 5'd0, in_rd, 5'd0, 6'b001001};
            5'd5:  enc = {11'd0, in_rt, in_rd, in_shamt, 6'b000000};
            5'd6:  enc = {6'b001101, in_rs, in_rt, imm16};
            5'd7:  enc = {6'b100011, in_rs, in_rt, imm16};
            5'd8:  enc = {6'b101011, in_rs, in_rt, imm16};
            5'd9:  enc = {6'b000100, in_rs, in_rt, imm16};
            5'd10: enc = {6'b001111, 5'd0, in_rt, imm16};
            5'd11: enc = {6'b000011, in_imm};
            5'd12: enc = {6'b000010, in_imm};
            5'd13: enc = {6'b100000, in_rs, in_rt, imm16};
            5'd14: enc = {6'b000111, in_rs, 5'd0, imm16};
            5'd15: enc = {6'b001000, in_rs, in_rt, imm16};
            5'd16: enc = {6'b101100, in_rs, in_rt, imm16};
            default: op_ok = 1'b0;
        endcase
    end

    assign full      = count == (AW+1)'(DEPTH);
    assign empty     = count == '0;
    assign in_ready  = (state == LOAD) && !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && op_ok && !clear;
    assign mem_we    = !empty;
    assign mem_wdata = empty ? 32'd0 : fifo[rd_ptr][31:0];
    assign head_last = fifo[rd_ptr][32];
    assign pop       = mem_we && mem_ack && !clear;
    assign done      = state == DONE;

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= {in_last, enc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mem_addr <= BASE_ADDR;
            err      <= 1'b0;
        end else if (clear) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mem_addr <= BASE_ADDR;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                mem_addr <= mem_addr + 32'd4;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (accept && !op_ok) err <= 1'b1;
        end
    end

    // Nothing is pushed in DRAIN, so the last-flagged word is always the final one left.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = (accept && in_last) ? DRAIN : LOAD;
            DRAIN:   state_nxt = (empty || (pop && (head_last || count == (AW+1)'(1)))) ? DONE : DRAIN;
            default: state_nxt = DONE;
        endcase
    end

`ifdef ENC_WRCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wr_count <= '0;
        else if (clear) wr_count <= '0;
        else if (pop && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
`endif
endmodule
